// File: rtl/voice_mixer.sv
// Time-multiplexed voice summer: accumulates N_VOICES signed samples per frame
// and emits one saturated output sample per frame over a valid/ready stream.
module voice_mixer #(
    parameter int unsigned N_VOICES = 8,
    parameter int unsigned WI_IN    = 2,
    parameter int unsigned WF_IN    = 14,
    parameter int unsigned WI_OUT   = 1,
    parameter int unsigned WF_OUT   = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WI_IN+WF_IN-1:0]      s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [WI_OUT+WF_OUT-1:0]    m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        ovf,
    output logic                        frame_err
);

    localparam int unsigned GUARD = $clog2(N_VOICES);
    localparam int unsigned W_IN  = WI_IN + WF_IN;
    localparam int unsigned W_OUT = WI_OUT + WF_OUT;
    localparam int unsigned W_ACC = WI_IN + GUARD + WF_IN;
    localparam int unsigned CNT_W = GUARD;
    localparam int unsigned W_IX  = (WI_IN + GUARD > WI_OUT) ? WI_IN + GUARD : WI_OUT;
    localparam int unsigned W_FX  = (WF_IN > WF_OUT) ? WF_IN : WF_OUT;
    localparam int unsigned W_X   = W_IX + W_FX;
    localparam int unsigned SH_UP = W_FX - WF_IN;
    localparam int unsigned SH_DN = W_FX - WF_OUT;

    localparam logic [W_OUT-1:0] SAT_NEG = W_OUT'(1) << (W_OUT - 1);
    localparam logic [W_OUT-1:0] SAT_POS = ~SAT_NEG;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_VOICES - 1);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t                    state;
    logic signed [W_ACC-1:0]   acc;
    logic [CNT_W-1:0]          cnt;

    logic signed [W_IN-1:0]    sample_c;
    logic signed [W_ACC-1:0]   sum_c;
    logic signed [W_X-1:0]     wide_c;
    logic signed [W_X-1:0]     aligned_c;
    logic                      fits_c;
    logic                      last_c;
    logic [W_OUT-1:0]          conv_c;
    logic                      conv_ovf_c;

    // Full frame sum including the current beat, aligned to the output binary point.
    always_comb begin
        sample_c   = s_data;
        sum_c      = acc + W_ACC'(sample_c);
        wide_c     = W_X'(sum_c) <<< SH_UP;
        aligned_c  = wide_c >>> SH_DN;
        fits_c     = (aligned_c == W_X'($signed(aligned_c[W_OUT-1:0])));
        last_c     = (cnt == CNT_LAST);
        conv_ovf_c = !fits_c;
        if (fits_c) begin
            conv_c = aligned_c[W_OUT-1:0];
        end else if (aligned_c[W_X-1]) begin
            conv_c = SAT_NEG;
        end else begin
            conv_c = SAT_POS;
        end
    end

    // Frame FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            m_data    <= '0;
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (s_valid && s_ready) begin
                        if (s_last != last_c) begin
                            frame_err <= 1'b1;
                        end
                        if (last_c) begin
                            m_data  <= conv_c;
                            ovf     <= conv_ovf_c;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= ST_OUT;
                            s_ready <= 1'b0;
                            m_valid <= 1'b1;
                        end else begin
                            acc <= sum_c;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        state   <= ST_ACC;
                        s_ready <= 1'b1;
                        m_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_ACC;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed self-checking bench for voice_mixer with default parameters.
module tb_voice_mixer;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        ovf;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    voice_mixer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .ovf       (ovf),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One beat; inputs change 1 time unit after the active edge.
    task automatic send(input logic [15:0] d, input logic last);
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] d);
        for (int i = 0; i < 8; i++) send(d, i == 7);
    endtask

    task automatic expect_out(input string tag, input logic [15:0] d, input logic o);
        check({tag, "_mvalid"}, 32'(m_valid), 32'd1);
        check({tag, "_sready"}, 32'(s_ready), 32'd0);
        check({tag, "_data"}, 32'(m_data), 32'(d));
        check({tag, "_ovf"}, 32'(ovf), 32'(o));
    endtask

    task automatic drain(input string tag);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check({tag, "_drain_mvalid"}, 32'(m_valid), 32'd0);
        check({tag, "_drain_sready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sready", 32'(s_ready), 32'd1);
        check("rst_mvalid", 32'(m_valid), 32'd0);
        check("rst_mdata", 32'(m_data), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal: 8 x 0.0625 = 0.5
        for (int i = 0; i < 7; i++) send(16'h0400, 1'b0);
        check("nom_mvalid_pre", 32'(m_valid), 32'd0);
        send(16'h0400, 1'b1);
        expect_out("nom", 16'h4000, 1'b0);
        check("nom_ferr", 32'(frame_err), 32'd0);
        drain("nom");

        // Positive saturation: 8 x 0.5 = 4.0
        send_frame(16'h2000);
        expect_out("psat", 16'h7FFF, 1'b1);
        drain("psat");

        // Negative saturation: 8 x -0.5 = -4.0
        send_frame(16'hE000);
        expect_out("nsat", 16'h8000, 1'b1);
        drain("nsat");

        // Cancellation: 4 x 1.0 + 4 x -1.0
        for (int i = 0; i < 4; i++) send(16'h4000, 1'b0);
        for (int i = 0; i < 4; i++) send(16'hC000, i == 3);
        expect_out("cancel", 16'h0000, 1'b0);
        drain("cancel");

        // Gaps mid-frame, then downstream backpressure
        for (int i = 0; i < 4; i++) send(16'h0400, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("gap_sready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 4; i++) send(16'h0400, i == 3);
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("bp%0d", i), 16'h4000, 1'b0);
            @(posedge clk);
            #1;
        end
        expect_out("bp_end", 16'h4000, 1'b0);
        drain("bp");

        // Reset mid-frame discards the partial sum
        for (int i = 0; i < 3; i++) send(16'h7FFF, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_sready", 32'(s_ready), 32'd1);
        check("mrst_mvalid", 32'(m_valid), 32'd0);
        check("mrst_mdata", 32'(m_data), 32'd0);
        check("mrst_ovf", 32'(ovf), 32'd0);
        check("mrst_ferr", 32'(frame_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(16'h0400);
        expect_out("mrst", 16'h4000, 1'b0);
        check("mrst_ferr_after", 32'(frame_err), 32'd0);
        drain("mrst");

        // Misplaced s_last on beat 3: sticky error, framing follows the counter
        for (int i = 0; i < 8; i++) begin
            send(16'h0400, (i == 2) || (i == 7));
            if (i == 2) check("ferr_set", 32'(frame_err), 32'd1);
            if (i == 3) check("ferr_mvalid_mid", 32'(m_valid), 32'd0);
        end
        expect_out("ferr", 16'h4000, 1'b0);
        drain("ferr");
        check("ferr_sticky", 32'(frame_err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
